// File: rtl/lemmings_pkg.sv
// Shared constants for the Lemmings2 world model.
// Holds the default world geometry, the reset hole layout, the fall length
// and the width of the optional statistics counters.
package lemmings_pkg;

  localparam int unsigned WORLD_LEN_D = 8;
  localparam int unsigned POS_W_D     = 3;
  localparam int unsigned START_POS_D = 3;
  localparam logic [7:0]  HOLE_MAP_D  = 8'b0010_0000;
  localparam int unsigned FALL_LEN_D  = 4;

  localparam int unsigned STAT_W = 8;

endpackage

// File: rtl/lemmings_fall_timer.sv
// Fall timer for the Lemmings2 world model.
// Counts the cycles the lemming spends without ground and pulses bridge_o on
// the cycle the hole under it must be filled in.
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   ground_i  ground present under the lemming
//   bridge_o  one-cycle pulse: the current hole is bridged at this edge
module lemmings_fall_timer #(
  parameter int unsigned FallLen = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ground_i,
  output logic bridge_o
);

  localparam logic [3:0] CntLast = 4'(FallLen - 1);

  logic [3:0] fall_cnt_q, fall_cnt_d;

  // The lemming has already spent FallLen-1 cycles falling when this fires,
  // so together with the current cycle ground stays low for FallLen cycles.
  assign bridge_o = ~ground_i & (fall_cnt_q == CntLast);

  always_comb begin
    fall_cnt_d = fall_cnt_q + 4'd1;
    if (ground_i || bridge_o) begin
      fall_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fall_cnt_q <= 4'd0;
    end else begin
      fall_cnt_q <= fall_cnt_d;
    end
  end

endmodule

// File: rtl/lemmings_world.sv
// Environment model for the Lemmings2 walker FSM.
// Takes the walker's walk_left / walk_right / aaah and answers with
// bump_left / bump_right / ground for a 1-D world of WORLD_LEN cells with
// walls at both ends. A hole is bridged for good once the lemming has been
// falling in it for FALL_LEN cycles.
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   walk_left, walk_right    walker direction
//   aaah                     walker is falling
//   bump_left, bump_right    lemming stands against the left / right wall
//   ground                   ground present under the lemming
//   pos                      current cell
//   protocol_err             sticky flag for illegal input combinations
//   bump_count, fall_count   saturating statistics, only with
//                            LEMMINGS_WORLD_STATS_EN defined
module lemmings_world
  import lemmings_pkg::*;
#(
  parameter int unsigned          WORLD_LEN = WORLD_LEN_D,
  parameter int unsigned          POS_W     = POS_W_D,
  parameter int unsigned          START_POS = START_POS_D,
  parameter logic [WORLD_LEN-1:0] HOLE_MAP  = WORLD_LEN'(HOLE_MAP_D),
  parameter int unsigned          FALL_LEN  = FALL_LEN_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              walk_left,
  input  logic              walk_right,
  input  logic              aaah,
  output logic              bump_left,
  output logic              bump_right,
  output logic              ground,
  output logic [POS_W-1:0]  pos,
`ifdef LEMMINGS_WORLD_STATS_EN
  output logic [STAT_W-1:0] bump_count,
  output logic [STAT_W-1:0] fall_count,
`endif
  output logic              protocol_err
);

  localparam logic [POS_W-1:0] PosLast  = POS_W'(WORLD_LEN - 1);
  localparam logic [POS_W-1:0] PosStart = POS_W'(START_POS);

  logic [POS_W-1:0]     pos_q, pos_d;
  logic [WORLD_LEN-1:0] hole_q, hole_d;
  logic                 err_q;
  logic                 illegal;
  logic                 move;
  logic                 bridge;

  assign ground       = ~hole_q[pos_q];
  assign bump_left    = ground & (pos_q == '0);
  assign bump_right   = ground & (pos_q == PosLast);
  assign pos          = pos_q;
  assign protocol_err = err_q;

  // Opposing walks, or falling while still claiming to walk.
  assign illegal = (walk_left & walk_right) | (aaah & (walk_left | walk_right));
  assign move    = ground & ~aaah & ~illegal;

  lemmings_fall_timer #(
    .FallLen (FALL_LEN)
  ) u_fall_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .ground_i (ground),
    .bridge_o (bridge)
  );

  always_comb begin
    pos_d  = pos_q;
    hole_d = hole_q;
    // Walking into a wall holds the position; the walker turns on that edge.
    if (move && walk_left && (pos_q != '0)) begin
      pos_d = pos_q - 1'b1;
    end else if (move && walk_right && (pos_q != PosLast)) begin
      pos_d = pos_q + 1'b1;
    end
    if (bridge) begin
      hole_d[pos_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= PosStart;
      hole_q <= HOLE_MAP;
      err_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      hole_q <= hole_d;
      err_q  <= err_q | illegal;
    end
  end

`ifdef LEMMINGS_WORLD_STATS_EN
  logic [STAT_W-1:0] bump_count_q, fall_count_q;
  logic              bump_hit;

  assign bump_hit   = (walk_left & bump_left) | (walk_right & bump_right);
  assign bump_count = bump_count_q;
  assign fall_count = fall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bump_count_q <= '0;
      fall_count_q <= '0;
    end else begin
      if (bump_hit && (bump_count_q != '1)) begin
        bump_count_q <= bump_count_q + 1'b1;
      end
      if (bridge && (fall_count_q != '1)) begin
        fall_count_q <= fall_count_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lemmings_world.sv
// Directed bench for lemmings_world with default parameters. The bench plays
// the walker by hand; statistics checks are compiled in only when
// LEMMINGS_WORLD_STATS_EN is defined.
module tb_lemmings_world;

  logic       clk;
  logic       rst_n;
  logic       walk_left;
  logic       walk_right;
  logic       aaah;
  logic       bump_left;
  logic       bump_right;
  logic       ground;
  logic [2:0] pos;
  logic       protocol_err;
`ifdef LEMMINGS_WORLD_STATS_EN
  logic [7:0] bump_count;
  logic [7:0] fall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  lemmings_world dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .walk_left    (walk_left),
    .walk_right   (walk_right),
    .aaah         (aaah),
    .bump_left    (bump_left),
    .bump_right   (bump_right),
    .ground       (ground),
    .pos          (pos),
`ifdef LEMMINGS_WORLD_STATS_EN
    .bump_count   (bump_count),
    .fall_count   (fall_count),
`endif
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic r, input logic a);
    walk_left  = l;
    walk_right = r;
    aaah       = a;
  endtask

  initial begin
    // 1. Reset, walker heading left.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    #12;
    chk("rst_pos", 8'(pos), 8'd3);
    chk("rst_ground", 8'(ground), 8'd1);
    chk("rst_bump_l", 8'(bump_left), 8'd0);
    chk("rst_bump_r", 8'(bump_right), 8'd0);
    chk("rst_err", 8'(protocol_err), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("walk_l_pos2", 8'(pos), 8'd2);
    tick();
    tick();
    chk("walk_l_pos0", 8'(pos), 8'd0);
    chk("left_wall_bump", 8'(bump_left), 8'd1);
    tick();
    chk("left_wall_hold", 8'(pos), 8'd0);
    chk("left_wall_bump2", 8'(bump_left), 8'd1);

    // 2. Walk right onto the hole at 5 and fall for four cycles.
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("walk_r_pos1", 8'(pos), 8'd1);
    chk("walk_r_bump_l", 8'(bump_left), 8'd0);
    tick();
    tick();
    tick();
    tick();
    chk("hole_pos", 8'(pos), 8'd5);
    chk("fall_c1_ground", 8'(ground), 8'd0);
    tick();  // aaah is one cycle late, so walk_right is still up here
    chk("fall_c2_ground", 8'(ground), 8'd0);
    chk("fall_c2_pos", 8'(pos), 8'd5);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("fall_c3_ground", 8'(ground), 8'd0);
    tick();
    chk("fall_c4_ground", 8'(ground), 8'd0);
    chk("fall_c4_pos", 8'(pos), 8'd5);
    tick();
    chk("bridged_ground", 8'(ground), 8'd1);
    chk("bridged_pos", 8'(pos), 8'd5);
    tick();  // walker still reports aaah for one cycle
    chk("aaah_hold_pos", 8'(pos), 8'd5);
    chk("no_err_fall", 8'(protocol_err), 8'd0);

    // 3. Resume right to the wall, then turn back over the bridged hole.
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("resume_pos6", 8'(pos), 8'd6);
    tick();
    chk("right_wall_pos", 8'(pos), 8'd7);
    chk("right_wall_bump", 8'(bump_right), 8'd1);
    tick();
    chk("right_wall_hold", 8'(pos), 8'd7);
    chk("right_wall_bump2", 8'(bump_right), 8'd1);
    drive(1'b1, 1'b0, 1'b0);
    tick();
    chk("back_pos6", 8'(pos), 8'd6);
    chk("back_bump_r", 8'(bump_right), 8'd0);
    tick();
    chk("back_pos5", 8'(pos), 8'd5);
    chk("back_bridge_ground", 8'(ground), 8'd1);
    tick();
    chk("back_pos4", 8'(pos), 8'd4);

`ifdef LEMMINGS_WORLD_STATS_EN
    // 6. Statistics after scenarios 1-3.
    chk("stat_bump_count", bump_count, 8'd2);
    chk("stat_fall_count", fall_count, 8'd1);
`endif

    // 4. Illegal input for one cycle.
    drive(1'b1, 1'b1, 1'b0);
    chk("err_before_edge", 8'(protocol_err), 8'd0);
    tick();
    chk("illegal_pos", 8'(pos), 8'd4);
    chk("illegal_err", 8'(protocol_err), 8'd1);
    drive(1'b1, 1'b0, 1'b0);
    tick();
    chk("legal_again_pos", 8'(pos), 8'd3);
    chk("err_sticky", 8'(protocol_err), 8'd1);

    // 5a. Asynchronous reset restores the world and clears the error.
    drive(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_err", 8'(protocol_err), 8'd0);
    chk("areset_pos", 8'(pos), 8'd3);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("refall_pos", 8'(pos), 8'd5);
    chk("refall_ground", 8'(ground), 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1);

    // 5b. Reset in the second cycle of a fall.
    #2 rst_n = 1'b0;
    #1;
    chk("midfall_pos", 8'(pos), 8'd3);
    chk("midfall_ground", 8'(ground), 8'd1);
    chk("midfall_err", 8'(protocol_err), 8'd0);
`ifdef LEMMINGS_WORLD_STATS_EN
    chk("midfall_bump_count", bump_count, 8'd0);
    chk("midfall_fall_count", fall_count, 8'd0);
`endif
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("post_rst_hole_pos", 8'(pos), 8'd5);
    chk("post_rst_hole_ground", 8'(ground), 8'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("post_rst_fall_c4", 8'(ground), 8'd0);
    tick();
    chk("post_rst_bridged", 8'(ground), 8'd1);
    chk("post_rst_bridged_pos", 8'(pos), 8'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lemmings_world.md
Name: lemmings_world

Overview:
- Environment model for the Lemmings2 walker FSM: the other end of its interface.
- Consumes walk_left / walk_right / aaah and drives bump_left / bump_right / ground.
- Tracks the lemming's position in a 1-D world of WORLD_LEN cells, with walls at both ends and parameterised holes.
- A hole is bridged permanently after the lemming has fallen in it for FALL_LEN cycles. Used as a closed-loop bench partner and an on-board demo.

Parameters:
- WORLD_LEN, 8, number of cells; walls left of cell 0 and right of cell WORLD_LEN-1.
- POS_W, 3, position width; must satisfy 2**POS_W >= WORLD_LEN.
- START_POS, 3, position loaded on reset.
- HOLE_MAP, 8'b0010_0000, bit i = 1 means cell i is a hole at reset.
- FALL_LEN, 4, cycles ground stays low before the hole is bridged; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- walk_left  input  1  lemming walking left.
- walk_right  input  1  lemming walking right.
- aaah  input  1  lemming falling.
- bump_left  output  1  lemming at left wall.
- bump_right  output  1  lemming at right wall.
- ground  output  1  ground present under lemming.
- pos  output  POS_W  current cell.
- protocol_err  output  1  sticky illegal-input flag.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- State: pos_q, hole_q[WORLD_LEN-1:0], fall_cnt[3:0], err_q.
- Reset: pos_q=START_POS, hole_q=HOLE_MAP, fall_cnt=0, err_q=0.
- Combinational outputs:
  - ground = ~hole_q[pos_q].
  - bump_left = ground & (pos_q==0).
  - bump_right = ground & (pos_q==WORLD_LEN-1).
- Values after reset: ground=~HOLE_MAP[START_POS]; bumps follow from the rules above.
- Illegal input: walk_left & walk_right, or aaah with either walk.
  - Sets err_q at the next edge; err_q clears only on reset.
  - The cycle with illegal input causes no movement.
- Move enable: move = ground & ~aaah & legal.
  - walk_left & pos_q>0: pos_q-1 at the edge.
  - walk_right & pos_q<WORLD_LEN-1: pos_q+1 at the edge.
  - Walking into a wall holds pos_q and keeps the bump high. The walker turns on that edge; no wrap-around ever.
- Fall timing:
  - ground==0: fall_cnt increments each edge.
  - When fall_cnt==FALL_LEN-1 and ground==0: at the edge, clear hole_q[pos_q] and fall_cnt returns to 0. ground rises the following cycle.
  - ground==1: fall_cnt=0.
- Latency of one fall:
  - The edge moving onto the hole is followed by exactly FALL_LEN cycles of ground=0.
  - Movement resumes on the first edge with ground=1 and aaah=0. This is one cycle after ground returns, because the walker's aaah is registered.
- No movement while ground==0, regardless of inputs.
- Holes at cell 0 or WORLD_LEN-1: bumps are suppressed while ground==0 and reassert once bridged.
- Reset mid-fall: all holes are restored from HOLE_MAP and pos returns to START_POS.

Optional Feature:
- Macro: LEMMINGS_WORLD_STATS_EN.
- Defined: adds outputs bump_count[7:0] and fall_count[7:0]. Both reset to 0 and saturate at 255.
  - bump_count increments on an edge with (walk_left&bump_left)|(walk_right&bump_right).
  - fall_count increments on each edge where a hole bit is cleared.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package lemmings_pkg holds:
  - default constants WORLD_LEN_D, POS_W_D, START_POS_D, HOLE_MAP_D, FALL_LEN_D;
  - stats counter width STAT_W=8.
- One natural sub-module, lemmings_fall_timer: holds fall_cnt and emits a one-cycle bridge pulse given ground and FALL_LEN. hole_q, pos_q and the error flag stay in the top.

Test Plan:
1. Reset with defaults and the walker in walk_left: expect pos=3, ground=1.
   - After 3 edges, pos=0 and bump_left=1. The next edge turns the walker to walk_right.
2. Continue walking right from 0:
   - pos reaches 5 and ground=0; aaah asserts 1 cycle later.
   - ground stays 0 for exactly 4 cycles, then 1; pos stays 5 throughout.
   - Walking resumes 1 cycle after ground returns.
3. Continue right to 7: bump_right=1, the walker turns left.
   - Walking back over cell 5 keeps ground=1 (hole bridged); pos runs 7,6,5,4...
4. Force walk_left=walk_right=1 for 1 cycle: pos unchanged, protocol_err=1 and remaining 1 after inputs return legal.
5. Assert rst_n=0 asynchronously during cycle 2 of a fall: pos=3, ground=1 immediately; hole at 5 restored (re-fall on revisit); protocol_err=0.
6. With LEMMINGS_WORLD_STATS_EN defined, run scenarios 1-3: bump_count=2, fall_count=1. Without the macro, the same bench compiles with the stats checks disabled.
